// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: one outstanding memory read at a time.
// Fetched words go into a DEPTH-entry FIFO, which is flushed on core redirects.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
  input  logic        out_ready
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t                  r_state;
  logic [15:0]             r_fetch_pc;
  logic                    r_mem_req;
  logic [15:0]             r_mem_addr;
  logic [DEPTH-1:0][15:0]  r_instr;
  logic [DEPTH-1:0][15:0]  r_pc;
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_next_count;
  logic          w_space;
  logic [15:0]   w_pc_inc;
  logic [15:0]   w_redir_pc;

  // A redirect cancels both the pop and any push in its cycle.
  assign w_pop        = (r_count != '0) && out_ready && !redirect;
  assign w_push       = (r_state == WAIT) && mem_ack && !redirect;
  assign w_next_count = r_count + CW'(w_push) - CW'(w_pop);
  assign w_space      = (w_next_count < FULL);
  assign w_pc_inc     = r_fetch_pc + 16'd2;
  assign w_redir_pc   = {redirect_pc[15:1], 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
    end else begin
      case (r_state)
        IDLE: begin
          if (redirect) begin
            r_fetch_pc <= w_redir_pc;
            r_mem_addr <= w_redir_pc;
          end else if (w_space) begin
            r_state    <= WAIT;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
          end
        end
        WAIT: begin
          if (redirect) begin
            r_fetch_pc <= w_redir_pc;
            if (mem_ack) begin
              r_state    <= IDLE;
              r_mem_req  <= 1'b0;
              r_mem_addr <= w_redir_pc;
            end else begin
              // Old address stays on the bus until memory answers it.
              r_state <= DISCARD;
            end
          end else if (mem_ack) begin
            r_fetch_pc <= w_pc_inc;
            r_mem_addr <= w_pc_inc;
            if (!w_space) begin
              r_state   <= IDLE;
              r_mem_req <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (redirect) r_fetch_pc <= w_redir_pc;
          if (mem_ack) begin
            r_state    <= IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= redirect ? w_redir_pc : r_fetch_pc;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr  <= '0;
      r_pc     <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_instr[r_wr_ptr] <= mem_rdata;
        r_pc[r_wr_ptr]    <= r_fetch_pc;
        r_wr_ptr          <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_next_count;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign out_valid = (r_count != '0);
  assign out_instr = r_instr[r_rd_ptr];
  assign out_pc    = r_pc[r_rd_ptr];
endmodule
